if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS core; directly upstream of the decode stage. Consumes the decode stage's branch bus and produces the IF-to-ID instruction bus.
- Contains:
  - a pre-IF next-PC selector that drives the synchronous instruction SRAM;
  - an IF register holding the fetched instruction;
  - a one-entry hold buffer for SRAM data during decode back-pressure;
  - a pending-branch register so every branch redirects exactly once, after its delay slot.

---
 rtl/if_stage_pkg.sv | 25 ++
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage_hold_buffer.sv | 35 +++
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned DATA_W = 32;

  typedef logic [PC_W-1:0]   program_count_t;
  typedef logic [DATA_W-1:0] cpu_data_t;

  localparam program_count_t DEFAULT_RESET_VECTOR = 32'hbfc00000;

  // Branch bus driven combinationally by decode.
  typedef struct packed {
    logic           taken;
    program_count_t target;
  } id_to_if_branch_bus_t;

  // Instruction bus handed from fetch to decode.
  typedef struct packed {
    logic           valid;
    program_count_t program_count;
    cpu_data_t      instruction;
  } if_to_id_instruction_bus_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage connections: decode handshake, branch/instruction buses, instruction SRAM.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                      id_allow_in;
  id_to_if_branch_bus_t      id_to_if_branch_bus;
  if_to_id_instruction_bus_t if_to_id_instruction_bus;
  logic                      inst_sram_en;
  logic [3:0]                inst_sram_wen;
  program_count_t            inst_sram_addr;
  cpu_data_t                 inst_sram_wdata;
  cpu_data_t                 inst_sram_rdata;

  // Fetch-stage side.
  modport master (
    input  id_allow_in, id_to_if_branch_bus, inst_sram_rdata,
    output if_to_id_instruction_bus, inst_sram_en, inst_sram_wen,
           inst_sram_addr, inst_sram_wdata
  );

  // Environment side (decode stage and SRAM).
  modport slave (
    output id_allow_in, id_to_if_branch_bus, inst_sram_rdata,
    input  if_to_id_instruction_bus, inst_sram_en, inst_sram_wen,
           inst_sram_addr, inst_sram_wdata
  );

endinterface

// File: rtl/if_stage_hold_buffer.sv
// One-entry hold buffer: keeps SRAM read data alive while decode back-pressures.
module if_stage_hold_buffer
  import if_stage_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      fill,
  input  logic      clear,
  input  cpu_data_t rdata,
  output cpu_data_t instruction_c
);

  logic      buffer_valid;
  cpu_data_t buffer_data;

  // Capture only the first stalled cycle; later SRAM data is stale.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buffer_valid <= 1'b0;
      buffer_data  <= '0;
    end else if (clear) begin
      buffer_valid <= 1'b0;
    end else if (fill && !buffer_valid) begin
      buffer_valid <= 1'b1;
      buffer_data  <= rdata;
    end
  end

  // Present buffered data while held, otherwise the live SRAM output.
  always_comb begin
    instruction_c = rdata;
    if (buffer_valid) instruction_c = buffer_data;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC select, IF register, hold buffer, pending branch.
// Optional: define IF_FETCH_STALL_COUNT_EN to add the fetch_stall_count port.
module if_stage
  import if_stage_pkg::*;
#(
  parameter program_count_t RESET_VECTOR = DEFAULT_RESET_VECTOR
)(
  input logic        clock,
  input logic        reset,
  if_stage_if.master pipe
`ifdef IF_FETCH_STALL_COUNT_EN
  ,
  output logic [31:0] fetch_stall_count
`endif
);

  id_to_if_branch_bus_t branch;
  logic           if_valid;
  program_count_t if_pc;
  logic           pending_valid;
  program_count_t pending_target;
  logic           branch_consumed;

  logic           if_allow_in;
  logic           br_now;
  logic           br_early;
  logic           pend_use;
  logic           pend_set;
  logic           consumed_set;
  logic           consumed_clr;
  program_count_t next_pc;
  cpu_data_t      instruction_c;

  assign branch = pipe.id_to_if_branch_bus;

  // Handshake, redirect decisions and next-PC priority.
  always_comb begin
    if_allow_in  = !if_valid || pipe.id_allow_in;
    br_now       = branch.taken && !branch_consumed && if_valid;
    br_early     = branch.taken && !branch_consumed && !if_valid;
    pend_use     = pending_valid && !br_now && if_allow_in;
    pend_set     = (br_now && !if_allow_in) || br_early;
    consumed_set = (br_now && if_allow_in) || pend_use || pend_set;
    consumed_clr = pipe.id_allow_in && if_valid;
    next_pc      = if_pc + PC_W'(4);
    if (br_now) begin
      next_pc = branch.target;
    end else if (pending_valid) begin
      next_pc = pending_target;
    end
  end

  // IF register advances whenever the stage can accept a new fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_valid <= 1'b0;
      if_pc    <= RESET_VECTOR - PC_W'(4);
    end else if (if_allow_in) begin
      if_valid <= 1'b1;
      if_pc    <= next_pc;
    end
  end

  // Pending redirect: remembers a branch target until its fetch can issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_valid  <= 1'b0;
      pending_target <= '0;
    end else if (pend_set) begin
      pending_valid  <= 1'b1;
      pending_target <= branch.target;
    end else if (pend_use) begin
      pending_valid  <= 1'b0;
    end
  end

  // Blocks a second redirect while decode keeps asserting the same branch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      branch_consumed <= 1'b0;
    end else if (consumed_set) begin
      branch_consumed <= 1'b1;
    end else if (consumed_clr) begin
      branch_consumed <= 1'b0;
    end
  end

  if_stage_hold_buffer u_hold_buffer (
    .clock         (clock),
    .reset         (reset),
    .fill          (if_valid && !pipe.id_allow_in),
    .clear         (if_allow_in),
    .rdata         (pipe.inst_sram_rdata),
    .instruction_c (instruction_c)
  );

  // SRAM request and decode bus; everything reads as zero while in reset.
  always_comb begin
    pipe.inst_sram_en             = reset && if_allow_in;
    pipe.inst_sram_wen            = 4'b0000;
    pipe.inst_sram_wdata          = '0;
    pipe.inst_sram_addr           = '0;
    pipe.if_to_id_instruction_bus = '0;
    if (reset) pipe.inst_sram_addr = next_pc;
    if (if_valid) begin
      pipe.if_to_id_instruction_bus.valid         = 1'b1;
      pipe.if_to_id_instruction_bus.program_count = if_pc;
      pipe.if_to_id_instruction_bus.instruction   = instruction_c;
    end
  end

`ifdef IF_FETCH_STALL_COUNT_EN
  // Saturating count of cycles a valid instruction waits on decode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_stall_count <= '0;
    end else if (if_valid && !pipe.id_allow_in && fetch_stall_count != '1) begin
      fetch_stall_count <= fetch_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall hold, branch redirect rules, reset.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  if_stage_if pipe ();

`ifdef IF_FETCH_STALL_COUNT_EN
  logic [31:0] fetch_stall_count;
`endif

  if_stage #(.RESET_VECTOR(32'hbfc00000)) dut (
    .clock (clock),
    .reset (reset),
    .pipe  (pipe)
`ifdef IF_FETCH_STALL_COUNT_EN
    ,
    .fetch_stall_count (fetch_stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before sampling.
  task automatic step(input logic rst, input logic allow, input logic taken,
                      input logic [31:0] target, input logic [31:0] rdata);
    @(negedge clock);
    reset = rst;
    pipe.id_allow_in = allow;
    pipe.id_to_if_branch_bus = {taken, target};
    pipe.inst_sram_rdata = rdata;
    #1;
  endtask

  function automatic logic [64:0] bus(input logic [31:0] pc, input logic [31:0] inst);
    return {1'b1, pc, inst};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    pipe.id_allow_in = 1'b1;
    pipe.id_to_if_branch_bus = '0;
    pipe.inst_sram_rdata = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_bus", pipe.if_to_id_instruction_bus, 65'd0);
    chk("rst_en", pipe.inst_sram_en, 0);
    chk("rst_addr", pipe.inst_sram_addr, 0);
    chk("rst_wen", pipe.inst_sram_wen, 0);
    chk("rst_wdata", pipe.inst_sram_wdata, 0);
`ifdef IF_FETCH_STALL_COUNT_EN
    chk("rst_cnt", fetch_stall_count, 0);
`endif

    // Reset release: first fetch at the reset vector.
    step(1, 1, 0, 0, 32'h0);
    chk("c0_addr", pipe.inst_sram_addr, 32'hbfc00000);
    chk("c0_en", pipe.inst_sram_en, 1);
    chk("c0_bus", pipe.if_to_id_instruction_bus, 65'd0);
    step(1, 1, 0, 0, 32'h3c1d0000);
    chk("c1_addr", pipe.inst_sram_addr, 32'hbfc00004);
    chk("c1_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00000, 32'h3c1d0000));

    // Three stall cycles with IF holding bfc00004; SRAM then returns garbage.
    step(1, 0, 0, 0, 32'h24080001);
    chk("c2_addr", pipe.inst_sram_addr, 32'hbfc00008);
    chk("c2_en", pipe.inst_sram_en, 0);
    chk("c2_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00004, 32'h24080001));
    step(1, 0, 0, 0, 32'hdeadbeef);
    chk("c3_en", pipe.inst_sram_en, 0);
    chk("c3_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00004, 32'h24080001));
    step(1, 0, 0, 0, 32'h12345678);
    chk("c4_en", pipe.inst_sram_en, 0);
    chk("c4_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00004, 32'h24080001));
    step(1, 1, 0, 0, 32'hcafef00d);
    chk("c5_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00004, 32'h24080001));
    chk("c5_en", pipe.inst_sram_en, 1);
    chk("c5_addr", pipe.inst_sram_addr, 32'hbfc00008);

    // Branch at bfc00008 resolves in decode while IF holds the delay slot.
    step(1, 1, 0, 0, 32'h10000003);
    chk("c6_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00008, 32'h10000003));
    chk("c6_addr", pipe.inst_sram_addr, 32'hbfc0000c);
    step(1, 1, 1, 32'hbfc00100, 32'h24090002);
    chk("c7_addr", pipe.inst_sram_addr, 32'hbfc00100);
    chk("c7_en", pipe.inst_sram_en, 1);
    chk("c7_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc0000c, 32'h24090002));
    step(1, 1, 0, 0, 32'h3c010000);
    chk("c8_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00100, 32'h3c010000));
    chk("c8_addr", pipe.inst_sram_addr, 32'hbfc00104);

    // Decode stalls with taken held for four cycles: one redirect only.
    step(1, 0, 1, 32'hbfc00200, 32'h1111aaaa);
    chk("c9_addr", pipe.inst_sram_addr, 32'hbfc00200);
    chk("c9_en", pipe.inst_sram_en, 0);
    step(1, 0, 1, 32'hbfc00200, 32'h0badf00d);
    chk("c10_addr", pipe.inst_sram_addr, 32'hbfc00200);
    chk("c10_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00104, 32'h1111aaaa));
    step(1, 0, 1, 32'hbfc00200, 32'h0badf00e);
    chk("c11_en", pipe.inst_sram_en, 0);
    step(1, 1, 1, 32'hbfc00200, 32'h0badf00f);
    chk("c12_addr", pipe.inst_sram_addr, 32'hbfc00200);
    chk("c12_en", pipe.inst_sram_en, 1);
    chk("c12_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00104, 32'h1111aaaa));
    step(1, 1, 0, 0, 32'h22220000);
    chk("c13_addr", pipe.inst_sram_addr, 32'hbfc00204);
    chk("c13_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00200, 32'h22220000));

    // Reset asserted in the middle of a stall with the buffer loaded.
    step(1, 0, 0, 0, 32'h33330000);
    step(1, 0, 0, 0, 32'h77777777);
    chk("c15_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00204, 32'h33330000));
`ifdef IF_FETCH_STALL_COUNT_EN
    chk("cnt_pre_reset", fetch_stall_count, 7);
`endif
    reset = 1'b0;
    #1;
    chk("mid_rst_bus", pipe.if_to_id_instruction_bus, 65'd0);
    chk("mid_rst_en", pipe.inst_sram_en, 0);
    chk("mid_rst_addr", pipe.inst_sram_addr, 0);
`ifdef IF_FETCH_STALL_COUNT_EN
    chk("mid_rst_cnt", fetch_stall_count, 0);
`endif

    // Branch taken while IF is invalid: delay slot first, then target.
    step(1, 1, 1, 32'hbfc00300, 32'h88888888);
    chk("c16_addr", pipe.inst_sram_addr, 32'hbfc00000);
    chk("c16_bus", pipe.if_to_id_instruction_bus, 65'd0);
    step(1, 1, 0, 0, 32'h44440000);
    chk("c17_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00000, 32'h44440000));
    chk("c17_addr", pipe.inst_sram_addr, 32'hbfc00300);
    step(1, 1, 0, 0, 32'h55550000);
    chk("c18_addr", pipe.inst_sram_addr, 32'hbfc00304);
    chk("c18_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00300, 32'h55550000));

    // Five stall cycles for the stall counter.
    step(1, 0, 0, 0, 32'h66660000);
    chk("c19_addr", pipe.inst_sram_addr, 32'hbfc00308);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, $urandom);
      chk("stall_en", pipe.inst_sram_en, 0);
      chk("stall_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00304, 32'h66660000));
    end
    step(1, 1, 0, 0, $urandom);
    chk("c24_en", pipe.inst_sram_en, 1);
    chk("c24_bus", pipe.if_to_id_instruction_bus, bus(32'hbfc00304, 32'h66660000));
`ifdef IF_FETCH_STALL_COUNT_EN
    chk("cnt_five", fetch_stall_count, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
